debounce_bank: RTL and testbench
================================

# debounce_bank

Parametrised multi-channel glitch filter with hysteresis, the next generation of the single-channel filter. Each channel's filtered output changes level only after the raw input has held the opposite level for N consecutive qualified samples. Shorter excursions are discarded. The block sits between input synchronisers and control logic, adds a sample-strobe prescaler hook, and emits edge pulses.

## Interface
Parameters:
- CH, 4: number of independent channels, 1..32.
- N, 10: consecutive qualified samples required to accept a new level, 2..65535.
- RST_VAL, {CH{1'b0}}: per-channel reset level of `y`.
- Local CW = $clog2(N+1): counter width per channel.

Ports (one clock; reset is synchronous and active-high):
- clk, in, 1: sole clock; all state updates on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- ce, in, 1: sample qualifier; a clk edge with ce=0 leaves all state, counters and `y` unchanged.
- i, in, CH: raw inputs, already synchronous to clk (synchronisers are external).
- y, out, CH: filtered levels, registered.
- rise, out, CH: one-cycle pulse when the matching `y` bit goes 0→1.
- fall, out, CH: one-cycle pulse when the matching `y` bit goes 1→0.
- chg, out, 1: OR of rise|fall, registered and coincident with them.

## Operation
- One FSM per channel, states S_LO (stable low), C_HI (low, candidate high), S_HI (stable high), C_LO (high, candidate low), plus a CW-bit counter `cnt`.
- Every state change and counter update below happens only at edges where ce=1 and rst=0.
- S_LO: if i=1, go to C_HI and set cnt=1; otherwise stay and hold cnt=0.
- C_HI, checked in priority order:
  - i=0: go to S_LO, cnt=0.
  - else cnt==N-1: go to S_HI, y←1, rise←1, cnt=0.
  - else cnt←cnt+1.
- S_HI and C_LO mirror S_LO and C_HI with the levels swapped; acceptance sets y←0 and fall←1.
- A candidate is accepted only if its Nth sample still shows the candidate level. An abort on the final sample returns to the stable state.
- Illegal or unreachable state encodings go to S_LO with cnt=0 on the next edge, regardless of ce.
- y=0 in S_LO/C_HI and y=1 in S_HI/C_LO. `y` is a register, not decoded from state.
- rise, fall and chg default to 0 on every edge, including ce=0 edges, so each pulse lasts exactly one clk cycle.
- Channels are fully independent. Simultaneous acceptances on several channels set several rise/fall bits in the same cycle, and chg=1 once.
- The counter never exceeds N-1, so there is no wrap-around.

## Timing
- Reset: y=RST_VAL; rise=fall=0; chg=0; cnt=0. Channel state is S_HI where the RST_VAL bit is 1, otherwise S_LO. Reset overrides ce.
- Reset mid-count discards the candidate; the channel restarts from its reset state on the first edge after rst falls.
- Latency with ce held at 1: if i changes before edge k and stays, y changes at edge k+N-1 and is visible in the cycle after it. rise/fall/chg are asserted in that same cycle.
- With ce gated, latency is N qualified samples; edges with ce=0 do not count and do not break the run.
- An excursion lasting at most N-1 qualified samples produces no change on y, rise, fall or chg.
- Minimum time between successive y toggles on one channel: N qualified samples.

## Test plan
- Reset: hold rst=1 for 3 cycles with RST_VAL=4'b0101 and i toggling. Required: y=4'b0101, rise=fall=0 and chg=0 throughout and on the first cycle after release.
- Clean edge: N=4, ce=1, i[0] goes 0→1 before edge k and stays. Required: y[0]=1 and rise[0]=chg=1 after edge k+3; rise[0]=0 after edge k+4.
- Glitch rejection: N=4, i[1] high for exactly 3 edges, then low. Required: y[1] stays 0 and no pulse. Then hold it high for 4 edges. Required: y[1]=1 and rise[1]=1.
- Prescale: N=4 with ce=1 on every 3rd edge and i[2] high. Required: y[2] rises at the 4th ce=1 edge. The same test with a low sample at the 3rd ce edge keeps y[2]=0.
- Simultaneous channels: i[0] 0→1 and i[3] 1→0 on the same edge from settled states. Required: rise=4'b0001, fall=4'b1000 and chg=1 in the same single cycle.
- Mid-count reset: N=10, i[0] high for 7 edges, then rst for 1 cycle with i still high. Required: y[0] rises only after 10 further qualified high samples post-reset.

Source files
------------

// File: rtl/debounce_bank.sv
// Multi-channel glitch filter with hysteresis and edge pulses.
// A level is accepted after N consecutive qualified samples.
module debounce_bank #(
    parameter int            CH      = 4,
    parameter int            N       = 10,
    parameter logic [CH-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic [CH-1:0] i,
    output logic [CH-1:0] y,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall,
    output logic          chg
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_LO = 2'd0,
        C_HI = 2'd1,
        S_HI = 2'd2,
        C_LO = 2'd3
    } st_t;

    st_t           st_q  [CH];
    st_t           st_d  [CH];
    logic [CW-1:0] cnt_q [CH];
    logic [CW-1:0] cnt_d [CH];
    logic [CH-1:0] y_d;
    logic [CH-1:0] rise_d;
    logic [CH-1:0] fall_d;

    always_comb begin
        y_d    = y;
        rise_d = '0;
        fall_d = '0;
        for (int c = 0; c < CH; c++) begin
            st_d[c]  = st_q[c];
            cnt_d[c] = cnt_q[c];
            case (st_q[c])
                S_LO: if (ce) begin
                    if (i[c]) begin
                        st_d[c]  = C_HI;
                        cnt_d[c] = CW'(1);
                    end else begin
                        cnt_d[c] = '0;
                    end
                end
                C_HI: if (ce) begin
                    if (!i[c]) begin
                        st_d[c]  = S_LO;
                        cnt_d[c] = '0;
                    end else if (cnt_q[c] == LAST) begin
                        st_d[c]   = S_HI;
                        cnt_d[c]  = '0;
                        y_d[c]    = 1'b1;
                        rise_d[c] = 1'b1;
                    end else begin
                        cnt_d[c] = cnt_q[c] + CW'(1);
                    end
                end
                S_HI: if (ce) begin
                    if (!i[c]) begin
                        st_d[c]  = C_LO;
                        cnt_d[c] = CW'(1);
                    end else begin
                        cnt_d[c] = '0;
                    end
                end
                C_LO: if (ce) begin
                    if (i[c]) begin
                        st_d[c]  = S_HI;
                        cnt_d[c] = '0;
                    end else if (cnt_q[c] == LAST) begin
                        st_d[c]   = S_LO;
                        cnt_d[c]  = '0;
                        y_d[c]    = 1'b0;
                        fall_d[c] = 1'b1;
                    end else begin
                        cnt_d[c] = cnt_q[c] + CW'(1);
                    end
                end
                // unreachable encodings recover even while ce is low
                default: begin
                    st_d[c]  = S_LO;
                    cnt_d[c] = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                st_q[c]  <= RST_VAL[c] ? S_HI : S_LO;
                cnt_q[c] <= '0;
            end
            y    <= RST_VAL;
            rise <= '0;
            fall <= '0;
            chg  <= 1'b0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                st_q[c]  <= st_d[c];
                cnt_q[c] <= cnt_d[c];
            end
            y    <= y_d;
            rise <= rise_d;
            fall <= fall_d;
            chg  <= |(rise_d | fall_d);
        end
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: run-length reference model plus
// directed literal checks on two parameterisations.
module tb_debounce_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic [3:0] i;
    logic [3:0] ya, ra, fa;
    logic       ca;
    logic [3:0] yb, rb, fb;
    logic       cb;

    int vec  = 0;
    int miss = 0;

    always #5 clk = ~clk;

    debounce_bank #(.CH(4), .N(4), .RST_VAL(4'b0101)) dut_a (
        .clk(clk), .rst(rst), .ce(ce), .i(i),
        .y(ya), .rise(ra), .fall(fa), .chg(ca)
    );

    debounce_bank #(.CH(4), .N(10), .RST_VAL(4'b0000)) dut_b (
        .clk(clk), .rst(rst), .ce(ce), .i(i),
        .y(yb), .rise(rb), .fall(fb), .chg(cb)
    );

    task automatic chk(input string nm, input int act, input int exp);
        vec++;
        if (act != exp) begin
            miss++;
            $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: per channel, count consecutive qualified samples that
    // disagree with the filtered level; N of them flip the level.
    int         nn  [2] = '{4, 10};
    logic [3:0] rv  [2] = '{4'b0101, 4'b0000};
    logic [3:0] my  [2];
    logic [3:0] mr  [2];
    logic [3:0] mf  [2];
    int         run [2][4];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            mr[d] = '0;
            mf[d] = '0;
            if (rst) begin
                my[d] = rv[d];
                for (int c = 0; c < 4; c++) run[d][c] = 0;
            end else if (ce) begin
                for (int c = 0; c < 4; c++) begin
                    if (i[c] != my[d][c]) begin
                        run[d][c]++;
                        if (run[d][c] == nn[d]) begin
                            my[d][c] = i[c];
                            if (i[c]) mr[d][c] = 1'b1;
                            else      mf[d][c] = 1'b1;
                            run[d][c] = 0;
                        end
                    end else begin
                        run[d][c] = 0;
                    end
                end
            end
        end
        #1;
        chk("a_y",    int'(ya), int'(my[0]));
        chk("a_rise", int'(ra), int'(mr[0]));
        chk("a_fall", int'(fa), int'(mf[0]));
        chk("a_chg",  int'(ca), int'(|(mr[0] | mf[0])));
        chk("b_y",    int'(yb), int'(my[1]));
        chk("b_rise", int'(rb), int'(mr[1]));
        chk("b_fall", int'(fb), int'(mf[1]));
        chk("b_chg",  int'(cb), int'(|(mr[1] | mf[1])));
    end

    initial begin
        rst = 1'b1;
        ce  = 1'b1;
        i   = 4'b0000;

        // reset with toggling inputs
        repeat (3) begin
            @(negedge clk);
            chk("rst_y", int'(ya), 5);
            chk("rst_pulse", int'({ra, fa, ca}), 0);
            i = ~i;
        end
        rst = 1'b0;
        i   = 4'b0101;
        @(negedge clk);
        chk("rel_y", int'(ya), 5);
        chk("rel_pulse", int'({ra, fa, ca}), 0);
        i = 4'b0000;
        repeat (6) @(negedge clk);

        // clean edge, N=4
        i[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("clean_wait", int'(ya[0]), 0);
        end
        @(negedge clk);
        chk("clean_y", int'(ya[0]), 1);
        chk("clean_rise", int'(ra[0]), 1);
        chk("clean_chg", int'(ca), 1);
        @(negedge clk);
        chk("clean_rise_end", int'(ra[0]), 0);

        // glitch of N-1 samples, then a full run
        i[1] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("glitch_rise", int'(ra[1]), 0);
        end
        i[1] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("glitch_y", int'(ya[1]), 0);
        end
        i[1] = 1'b1;
        repeat (3) @(negedge clk);
        @(negedge clk);
        chk("glitch_acc_y", int'(ya[1]), 1);
        chk("glitch_acc_rise", int'(ra[1]), 1);

        // prescaled sampling: ce on every third edge
        i[2] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            ce = (k % 3 == 0);
            @(negedge clk);
            if (k == 6) chk("pre_early", int'(ya[2]), 0);
            if (k == 9) begin
                chk("pre_y", int'(ya[2]), 1);
                chk("pre_rise", int'(ra[2]), 1);
            end
        end
        ce   = 1'b1;
        i[2] = 1'b0;
        repeat (5) @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            ce   = (k % 3 == 0);
            i[2] = (k != 6);
            @(negedge clk);
            if (k == 9 || k == 11) chk("pre_abort_y", int'(ya[2]), 0);
        end
        ce   = 1'b1;
        i[2] = 1'b0;
        repeat (5) @(negedge clk);

        // simultaneous rise and fall
        i[0] = 1'b0;
        i[3] = 1'b1;
        repeat (6) @(negedge clk);
        i[0] = 1'b1;
        i[3] = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        chk("sim_rise", int'(ra), 1);
        chk("sim_fall", int'(fa), 8);
        chk("sim_chg", int'(ca), 1);
        @(negedge clk);
        chk("sim_after", int'({ra, fa, ca}), 0);

        // mid-count reset on the N=10 instance
        i[0] = 1'b0;
        repeat (12) @(negedge clk);
        i[0] = 1'b1;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (9) begin
            @(negedge clk);
            chk("mid_wait", int'(yb[0]), 0);
        end
        @(negedge clk);
        chk("mid_y", int'(yb[0]), 1);
        chk("mid_rise", int'(rb[0]), 1);

        // random traffic: busy then quiet inputs
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 499) == 0);
            ce  = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < 4; c++)
                if ($urandom_range(0, (k < 1500) ? 5 : 24) == 0)
                    i[c] = ~i[c];
        end
        rst = 1'b0;
        ce  = 1'b1;
        repeat (15) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
